// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative signed HI/LO multiply / multiply-accumulate unit
// for the EX stage. This unit owns the architectural HI and LO registers.
//   Clk, Reset (async, active-low)
//   Start, ALUCtl[4:0], HiLoWrite : request from ALU control decode
//   Flush                        : abort an in-flight multiply
//   A, B [WIDTH]                 : rs / rt operands
//   Busy, Done                   : registered status (Done is a 1-cycle pulse)
//   Hi, Lo [WIDTH]               : HI/LO registers
//   Result [WIDTH]               : low word of the last committed mul
module hilo_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       ALUCtl,
  input  logic             HiLoWrite,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             sign_q, sign_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             mult_op_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [PW-1:0]    signed_prod_c;
  logic [PW-1:0]    hilo_c;

  assign mult_op_c = (ALUCtl == OP_MULT) || (ALUCtl == OP_MADD) ||
                     (ALUCtl == OP_MSUB) || (ALUCtl == OP_MUL);

  // Magnitudes; the most negative value maps to 2^(WIDTH-1), still valid unsigned.
  assign abs_a_c = A[WIDTH-1] ? WIDTH'(-A) : A;
  assign abs_b_c = B[WIDTH-1] ? WIDTH'(-B) : B;

  assign signed_prod_c = sign_q ? PW'(-prod_q) : prod_q;
  assign hilo_c        = {hi_q, lo_q};

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start && HiLoWrite) begin
          if (mult_op_c) begin
            mcand_d  = PW'(abs_a_c);
            mplier_d = abs_b_c;
            prod_d   = '0;
            sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
            op_d     = ALUCtl;
            cnt_d    = '0;
            state_d  = S_RUN;
          end else if (ALUCtl == OP_MTHI) begin
            hi_d = A;
          end else if (ALUCtl == OP_MTLO) begin
            lo_d = A;
          end
        end
      end

      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          // Radix-2 shift-add: one multiplier bit per cycle.
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        // Commit regardless of Flush; accumulate wraps modulo 2^(2*WIDTH).
        unique case (op_q)
          OP_MADD: {hi_d, lo_d} = hilo_c + signed_prod_c;
          OP_MSUB: {hi_d, lo_d} = hilo_c - signed_prod_c;
          default: {hi_d, lo_d} = signed_prod_c;
        endcase
        if (op_q == OP_MUL) begin
          result_d = signed_prod_c[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Hi     = hi_q;
  assign Lo     = lo_q;
  assign Result = result_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences, and random ops against a 64-bit
// arithmetic reference model.
module tb_hilo_mult_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10011;

  logic         Clk, Reset, Start, HiLoWrite, Flush;
  logic [4:0]   ALUCtl;
  logic [W-1:0] A, B, Hi, Lo, Result;
  logic         Busy, Done;

  hilo_mult_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtl(ALUCtl),
    .HiLoWrite(HiLoWrite), .Flush(Flush), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .Result(Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int busy_bad;

  // Reference model state.
  logic [63:0]  m_hilo;
  logic [W-1:0] m_res;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
  endfunction

  task automatic model_apply(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    case (op)
      OP_MULT: m_hilo = p;
      OP_MADD: m_hilo = m_hilo + p;
      OP_MSUB: m_hilo = m_hilo - p;
      OP_MUL:  begin m_hilo = p; m_res = m_hilo[W-1:0]; end
      OP_MTHI: m_hilo[63:32] = a;
      OP_MTLO: m_hilo[31:0]  = a;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present one request for one cycle; returns just after the accepting edge.
  task automatic drive_op(input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic hlw);
    Start = 1'b1; HiLoWrite = hlw; ALUCtl = op; A = a; B = b;
    step();
    Start = 1'b0; HiLoWrite = 1'b0; ALUCtl = '0;
  endtask

  // Wait (bounded) for Done; Busy must stay high until then.
  task automatic wait_done(output int cyc);
    cyc = 0;
    busy_bad = 0;
    while (!Done && cyc < 60) begin
      if (Busy !== 1'b1) busy_bad++;
      step();
      cyc++;
    end
  endtask

  // Run a single op start-to-finish and check latency and status.
  task automatic run_op(input string nm, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    drive_op(op, a, b, 1'b1);
    model_apply(op, a, b);
    if (is_mul(op)) begin
      wait_done(cyc);
      chk({nm, "_latency"}, cyc, LAT);
      chk({nm, "_busy_hold"}, busy_bad, 0);
      chk({nm, "_done"}, Done, 1'b1);
      chk({nm, "_busy_end"}, Busy, 1'b0);
    end else begin
      chk({nm, "_busy"}, Busy, 1'b0);
      chk({nm, "_done"}, Done, 1'b0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int cyc;
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   ops[6];

    vecs[0] = '{OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0};
    vecs[1] = '{OP_MTHI, 32'h0,        32'h0,        32'h0,        32'hFFFFFFEB, 32'h0};
    vecs[2] = '{OP_MTLO, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0};
    vecs[3] = '{OP_MADD, 32'd1,        32'd1,        32'h1,        32'h0,        32'h0};
    vecs[4] = '{OP_MSUB, 32'd2,        32'd1,        32'h0,        32'hFFFFFFFE, 32'h0};
    vecs[5] = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        32'h0};
    vecs[6] = '{OP_MUL,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFB};

    ops[0] = OP_MULT; ops[1] = OP_MADD; ops[2] = OP_MSUB;
    ops[3] = OP_MUL;  ops[4] = OP_MTHI; ops[5] = OP_MTLO;

    Reset = 1'b0; Start = 1'b0; HiLoWrite = 1'b0; Flush = 1'b0;
    ALUCtl = '0; A = '0; B = '0;
    m_hilo = '0; m_res = '0;

    #12;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_result", Result, 32'h0);
    Reset = 1'b1;
    step();

    // Directed vector table (state carries from row to row).
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_hi", i), Hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), Lo, vecs[i].lo);
      chk($sformatf("vec%0d_res", i), Result, vecs[i].res);
      step();
    end

    // Unknown code and HiLoWrite=0 leave everything unchanged.
    drive_op(5'b00000, 32'h1234, 32'h5, 1'b1);
    chk("badop_busy", Busy, 1'b0);
    drive_op(OP_MTHI, 32'hABCD, 32'h0, 1'b0);
    chk("nohlw_hi", Hi, m_hilo[63:32]);
    chk("nohlw_lo", Lo, m_hilo[31:0]);

    // Start mult and mtlo during RUN are ignored.
    drive_op(OP_MULT, 32'd3, 32'd5, 1'b1);
    model_apply(OP_MULT, 32'd3, 32'd5);
    repeat (5) step();
    drive_op(OP_MULT, 32'd100, 32'd100, 1'b1);
    repeat (3) step();
    drive_op(OP_MTLO, 32'hDEAD, 32'h0, 1'b1);
    wait_done(cyc);
    chk("ign_latency", cyc, LAT - 10);
    chk("ign_busy_hold", busy_bad, 0);
    chk("ign_hi", Hi, 32'h0);
    chk("ign_lo", Lo, 32'd15);
    step();
    chk("ign_done_pulse", Done, 1'b0);
    chk("ign_no_second", Busy, 1'b0);

    // Flush at iteration 10 aborts without writeback.
    run_op("fl_mthi", OP_MTHI, 32'h12, 32'h0);
    run_op("fl_mtlo", OP_MTLO, 32'h34, 32'h0);
    drive_op(OP_MULT, 32'd3, 32'd4, 1'b1);
    repeat (10) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("fl_busy", Busy, 1'b0);
    chk("fl_done", Done, 1'b0);
    repeat (30) step();
    chk("fl_no_done", Done, 1'b0);
    chk("fl_hi", Hi, 32'h12);
    chk("fl_lo", Lo, 32'h34);
    // Flush with Start in IDLE: Start wins.
    Flush = 1'b1;
    drive_op(OP_MULT, 32'd3, 32'd4, 1'b1);
    Flush = 1'b0;
    model_apply(OP_MULT, 32'd3, 32'd4);
    wait_done(cyc);
    chk("fl2_latency", cyc, LAT);
    chk("fl2_hi", Hi, 32'h0);
    chk("fl2_lo", Lo, 32'd12);

    // Back-to-back: next op issued while Done is high.
    drive_op(OP_MADD, 32'hFFFFFFFB, 32'd4, 1'b1);
    model_apply(OP_MADD, 32'hFFFFFFFB, 32'd4);
    chk("b2b_done_drop", Done, 1'b0);
    wait_done(cyc);
    chk("b2b_latency", cyc, LAT);
    chk("b2b_hi", Hi, m_hilo[63:32]);
    chk("b2b_lo", Lo, m_hilo[31:0]);
    step();

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      run_op($sformatf("rnd%0d", i), op, a, b);
      chk($sformatf("rnd%0d_hi", i), Hi, m_hilo[63:32]);
      chk($sformatf("rnd%0d_lo", i), Lo, m_hilo[31:0]);
      chk($sformatf("rnd%0d_res", i), Result, m_res);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset at iteration 20 clears everything immediately.
    run_op("rs_mthi", OP_MTHI, 32'h55, 32'h0);
    drive_op(OP_MUL, 32'd7, 32'd7, 1'b1);
    repeat (20) step();
    #2;
    Reset = 1'b0;
    #1;
    chk("rs_busy", Busy, 1'b0);
    chk("rs_done", Done, 1'b0);
    chk("rs_hi", Hi, 32'h0);
    chk("rs_lo", Lo, 32'h0);
    chk("rs_result", Result, 32'h0);
    m_hilo = '0; m_res = '0;
    #3;
    Reset = 1'b1;
    step();
    run_op("rs_mult", OP_MULT, 32'd2, 32'd3);
    chk("rs_mult_lo", Lo, 32'd6);
    chk("rs_mult_hi", Hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
